// File: rtl/otter_fetch_unit_if.sv
// Instruction-memory port of the Otter fetch unit: valid/ready request channel plus valid-only response channel.
// Request: a transfer happens on a rising edge where req_valid && req_ready; the master holds req_valid and req_addr stable until then. Response: rsp_valid is a one-cycle strobe with no backpressure.
interface otter_fetch_unit_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/otter_fetch_unit.sv
// Otter PC register and single-outstanding instruction-fetch sequencer with redirect, kill and misalignment trap.
// All outputs are registered; o_dbg_state exposes the FSM state.
module otter_fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_redirect_valid,
  input  logic [31:0]        i_redirect_addr,
  input  logic               i_stall,
  otter_fetch_unit_if.master imem,
  output logic               o_inst_valid,
  output logic [31:0]        o_inst,
  output logic [31:0]        o_inst_pc,
  output logic               o_misalign_trap,
  output logic [31:0]        o_trap_addr,
  output logic [2:0]         o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_TRAP = 3'd4
  } state_t;

  state_t      r_state,      w_state_n;
  logic [31:0] r_pc,         w_pc_n;
  logic        r_kill,       w_kill_n;
  logic        r_trap_pend,  w_trap_pend_n;
  logic        r_req_valid,  w_req_valid_n;
  logic [31:0] r_req_addr,   w_req_addr_n;
  logic        r_inst_valid, w_inst_valid_n;
  logic [31:0] r_inst,       w_inst_n;
  logic [31:0] r_inst_pc,    w_inst_pc_n;
  logic        r_trap,       w_trap_n;
  logic [31:0] r_trap_addr,  w_trap_addr_n;

  logic w_redir_ok;
  logic w_redir_bad;
  logic w_hs;

  assign w_redir_ok  = i_redirect_valid && (i_redirect_addr[1:0] == 2'b00);
  assign w_redir_bad = i_redirect_valid && (i_redirect_addr[1:0] != 2'b00);
  assign w_hs        = r_req_valid && imem.req_ready;

  always_comb begin
    w_state_n      = r_state;
    w_pc_n         = r_pc;
    w_kill_n       = r_kill;
    w_trap_pend_n  = r_trap_pend;
    w_req_valid_n  = r_req_valid;
    w_req_addr_n   = r_req_addr;
    w_inst_valid_n = r_inst_valid;
    w_inst_n       = r_inst;
    w_inst_pc_n    = r_inst_pc;
    w_trap_n       = r_trap;
    w_trap_addr_n  = r_trap_addr;

    case (r_state)
      S_IDLE: begin
        if (w_redir_bad) begin
          w_trap_n      = 1'b1;
          w_trap_addr_n = i_redirect_addr;
          w_state_n     = S_TRAP;
        end else begin
          if (w_redir_ok) w_pc_n = i_redirect_addr;
          w_state_n = S_REQ;
        end
      end

      S_REQ: begin
        // The presented request cannot be withdrawn, so a redirect marks it for discard instead.
        if (w_redir_ok) begin
          w_pc_n        = i_redirect_addr;
          w_kill_n      = 1'b1;
          w_trap_n      = 1'b0;
          w_trap_pend_n = 1'b0;
        end else if (w_redir_bad) begin
          w_kill_n      = 1'b1;
          w_trap_pend_n = 1'b1;
          w_trap_n      = 1'b1;
          w_trap_addr_n = i_redirect_addr;
        end
        if (w_hs) begin
          w_req_valid_n = 1'b0;
          w_state_n     = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem.rsp_valid) begin
          if (w_redir_ok) begin
            w_pc_n        = i_redirect_addr;
            w_kill_n      = 1'b0;
            w_trap_n      = 1'b0;
            w_trap_pend_n = 1'b0;
            w_state_n     = S_REQ;
          end else if (w_redir_bad) begin
            w_kill_n      = 1'b0;
            w_trap_pend_n = 1'b0;
            w_trap_n      = 1'b1;
            w_trap_addr_n = i_redirect_addr;
            w_state_n     = S_TRAP;
          end else if (r_kill) begin
            w_kill_n      = 1'b0;
            w_trap_pend_n = 1'b0;
            w_state_n     = r_trap_pend ? S_TRAP : S_REQ;
          end else begin
            w_inst_n       = imem.rsp_data;
            w_inst_pc_n    = r_pc;
            w_inst_valid_n = 1'b1;
            w_state_n      = S_OUT;
          end
        end else if (w_redir_ok) begin
          w_pc_n        = i_redirect_addr;
          w_kill_n      = 1'b1;
          w_trap_n      = 1'b0;
          w_trap_pend_n = 1'b0;
        end else if (w_redir_bad) begin
          w_kill_n      = 1'b1;
          w_trap_pend_n = 1'b1;
          w_trap_n      = 1'b1;
          w_trap_addr_n = i_redirect_addr;
        end
      end

      S_OUT: begin
        if (w_redir_ok) begin
          w_pc_n         = i_redirect_addr;
          w_inst_valid_n = 1'b0;
          w_state_n      = S_REQ;
        end else if (w_redir_bad) begin
          w_inst_valid_n = 1'b0;
          w_trap_n       = 1'b1;
          w_trap_addr_n  = i_redirect_addr;
          w_state_n      = S_TRAP;
        end else if (!i_stall) begin
          w_pc_n         = r_pc + 32'd4;
          w_inst_valid_n = 1'b0;
          w_state_n      = S_REQ;
        end
      end

      S_TRAP: begin
        if (w_redir_ok) begin
          w_pc_n    = i_redirect_addr;
          w_trap_n  = 1'b0;
          w_state_n = S_REQ;
        end else if (w_redir_bad) begin
          w_trap_addr_n = i_redirect_addr;
        end
      end

      default: w_state_n = S_IDLE;
    endcase

    // Every entry into REQ presents a fresh request at the (possibly redirected) pc.
    if ((w_state_n == S_REQ) && (r_state != S_REQ)) begin
      w_req_valid_n = 1'b1;
      w_req_addr_n  = w_pc_n;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_VEC;
      r_kill       <= 1'b0;
      r_trap_pend  <= 1'b0;
      r_req_valid  <= 1'b0;
      r_req_addr   <= RESET_VEC;
      r_inst_valid <= 1'b0;
      r_inst       <= 32'd0;
      r_inst_pc    <= 32'd0;
      r_trap       <= 1'b0;
      r_trap_addr  <= 32'd0;
    end else begin
      r_state      <= w_state_n;
      r_pc         <= w_pc_n;
      r_kill       <= w_kill_n;
      r_trap_pend  <= w_trap_pend_n;
      r_req_valid  <= w_req_valid_n;
      r_req_addr   <= w_req_addr_n;
      r_inst_valid <= w_inst_valid_n;
      r_inst       <= w_inst_n;
      r_inst_pc    <= w_inst_pc_n;
      r_trap       <= w_trap_n;
      r_trap_addr  <= w_trap_addr_n;
    end
  end

  assign imem.req_valid  = r_req_valid;
  assign imem.req_addr   = r_req_addr;
  assign o_inst_valid    = r_inst_valid;
  assign o_inst          = r_inst;
  assign o_inst_pc       = r_inst_pc;
  assign o_misalign_trap = r_trap;
  assign o_trap_addr     = r_trap_addr;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_otter_fetch_unit.sv
// Bench for otter_fetch_unit: hand-written corner sequences, a redirect vector table, and a randomized run
// checked against an architectural PC-stream model with a bench-side instruction memory.
module tb_otter_fetch_unit;
  localparam logic [31:0] RV = 32'h0000_0100;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        redir_valid;
  logic [31:0] redir_addr;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        trap;
  logic [31:0] trap_addr;
  logic [2:0]  dbg_state;

  otter_fetch_unit_if imem ();

  otter_fetch_unit #(.RESET_VEC(RV)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_redirect_valid (redir_valid),
    .i_redirect_addr  (redir_addr),
    .i_stall          (stall),
    .imem             (imem),
    .o_inst_valid     (inst_valid),
    .o_inst           (inst),
    .o_inst_pc        (inst_pc),
    .o_misalign_trap  (trap),
    .o_trap_addr      (trap_addr),
    .o_dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // ---------------- memory driver ----------------
  bit          mem_auto;
  bit          pend;
  int          cnt;
  logic [31:0] pend_addr;
  bit          acc_now;
  logic [31:0] acc_addr;
  bit          prev_hold;
  logic [31:0] prev_req_addr;

  task automatic tick();
    @(posedge clk);
    #1;
    acc_now = 1'b0;
    if (mem_auto) begin
      if (prev_hold) begin
        chk("req_hold_valid", imem.req_valid, 1);
        chk("req_hold_addr", imem.req_addr, prev_req_addr);
      end
      if (pend) chk("one_outstanding", imem.req_valid, 0);
    end
    imem.rsp_valid = 1'b0;
    imem.req_ready = 1'b0;
    if (mem_auto) begin
      if (pend) begin
        if (cnt == 0) begin
          imem.rsp_valid = 1'b1;
          imem.rsp_data  = mem_fn(pend_addr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      imem.req_ready = ($urandom_range(0, 1) == 1);
      if (imem.req_valid && imem.req_ready) begin
        acc_now   = 1'b1;
        acc_addr  = imem.req_addr;
        pend      = 1'b1;
        pend_addr = imem.req_addr;
        cnt       = $urandom_range(0, 2);
      end
      prev_hold     = imem.req_valid && !imem.req_ready;
      prev_req_addr = imem.req_addr;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_valid"}, imem.req_valid, 0);
    chk({tag, "_req_addr"}, imem.req_addr, RV);
    chk({tag, "_inst_valid"}, inst_valid, 0);
    chk({tag, "_inst"}, inst, 0);
    chk({tag, "_inst_pc"}, inst_pc, 0);
    chk({tag, "_trap"}, trap, 0);
    chk({tag, "_trap_addr"}, trap_addr, 0);
  endtask

  task automatic wait_inst(input string name);
    int k = 0;
    while (!inst_valid && k < 60) begin
      tick();
      k++;
    end
    chk({name, "_inst_timeout"}, inst_valid, 1);
  endtask

  // ---------------- redirect vector table ----------------
  typedef struct {
    logic [31:0] target;
    logic        stall;
    logic        exp_trap;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] exp_pc;
  int          consumed;
  bit          in_trap;

  initial begin
    vecs[0] = '{32'h0000_1000, 1'b0, 1'b0, 32'h0000_1000};
    vecs[1] = '{32'h0000_2000, 1'b1, 1'b0, 32'h0000_2000};
    vecs[2] = '{32'h0000_0203, 1'b0, 1'b1, 32'h0000_0000};
    vecs[3] = '{32'h0000_0301, 1'b1, 1'b1, 32'h0000_0000};
    vecs[4] = '{32'h0000_3000, 1'b0, 1'b0, 32'h0000_3000};
    vecs[5] = '{32'h0000_0002, 1'b0, 1'b1, 32'h0000_0000};
    vecs[6] = '{32'h0000_0040, 1'b1, 1'b0, 32'h0000_0040};
    vecs[7] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 32'hFFFF_FFFC};

    mem_auto = 0; pend = 0; prev_hold = 0; cnt = 0;
    imem.req_ready = 0; imem.rsp_valid = 0; imem.rsp_data = 0;
    rst_n = 0; redir_valid = 0; redir_addr = 0; stall = 0;
    repeat (2) tick();
    check_reset("rst");

    // Basic fetch: first request at RESET_VEC, response one cycle after accept.
    rst_n = 1;
    tick();
    chk("s1_req_valid", imem.req_valid, 1);
    chk("s1_req_addr", imem.req_addr, 32'h100);
    imem.req_ready = 1; tick();
    chk("s1_wait_no_req", imem.req_valid, 0);
    imem.rsp_valid = 1; imem.rsp_data = 32'h0000_0013; tick();
    chk("s1_inst_valid", inst_valid, 1);
    chk("s1_inst", inst, 32'h13);
    chk("s1_inst_pc", inst_pc, 32'h100);
    tick();
    chk("s1_next_valid", imem.req_valid, 1);
    chk("s1_next_addr", imem.req_addr, 32'h104);
    chk("s1_inst_cleared", inst_valid, 0);

    // Stall holds the presented instruction.
    imem.req_ready = 1; tick();
    imem.rsp_valid = 1; imem.rsp_data = 32'h0000_0093; stall = 1; tick();
    chk("s2_inst_valid", inst_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s2_hold_valid", inst_valid, 1);
      chk("s2_hold_inst", inst, 32'h93);
      chk("s2_hold_pc", inst_pc, 32'h104);
      chk("s2_no_req", imem.req_valid, 0);
    end
    stall = 0; tick();
    chk("s2_next_addr", imem.req_addr, 32'h108);

    // Redirect in WAIT, stale response two cycles later.
    imem.req_ready = 1; tick();
    redir_valid = 1; redir_addr = 32'h200; tick(); redir_valid = 0;
    chk("s3_wait_no_req", imem.req_valid, 0);
    tick();
    imem.rsp_valid = 1; imem.rsp_data = 32'hDEAD_BEEF; tick();
    chk("s3_killed_inst_valid", inst_valid, 0);
    chk("s3_req_valid", imem.req_valid, 1);
    chk("s3_req_addr", imem.req_addr, 32'h200);
    imem.req_ready = 1; tick();
    imem.rsp_valid = 1; imem.rsp_data = 32'h1111_1111; tick();
    chk("s3_inst", inst, 32'h1111_1111);
    chk("s3_inst_pc", inst_pc, 32'h200);
    tick();
    chk("s3_next_addr", imem.req_addr, 32'h204);

    // Redirect and response in the same WAIT cycle.
    imem.req_ready = 1; tick();
    imem.rsp_valid = 1; imem.rsp_data = 32'hBAD0_BAD0;
    redir_valid = 1; redir_addr = 32'h200; tick(); redir_valid = 0;
    chk("s4_inst_valid", inst_valid, 0);
    chk("s4_req_valid", imem.req_valid, 1);
    chk("s4_req_addr", imem.req_addr, 32'h200);

    // Misaligned redirect from OUT, then recovery.
    imem.req_ready = 1; tick();
    imem.rsp_valid = 1; imem.rsp_data = 32'h33; tick();
    chk("s5_out_pc", inst_pc, 32'h200);
    redir_valid = 1; redir_addr = 32'h202; tick(); redir_valid = 0;
    chk("s5_trap", trap, 1);
    chk("s5_trap_addr", trap_addr, 32'h202);
    chk("s5_inst_valid", inst_valid, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("s5_no_req", imem.req_valid, 0);
    end
    chk("s5_trap_held", trap, 1);
    redir_valid = 1; redir_addr = 32'h80; tick(); redir_valid = 0;
    chk("s5_trap_clear", trap, 0);
    chk("s5_req_valid", imem.req_valid, 1);
    chk("s5_req_addr", imem.req_addr, 32'h80);
    imem.req_ready = 1; tick();
    imem.rsp_valid = 1; imem.rsp_data = 32'h44; tick();
    chk("s5_inst", inst, 32'h44);
    chk("s5_inst_pc", inst_pc, 32'h80);
    tick();

    // Misaligned redirect while a response is outstanding.
    imem.req_ready = 1; tick();
    redir_valid = 1; redir_addr = 32'h301; tick(); redir_valid = 0;
    chk("s5b_trap", trap, 1);
    chk("s5b_trap_addr", trap_addr, 32'h301);
    imem.rsp_valid = 1; imem.rsp_data = 32'h55; tick();
    chk("s5b_inst_valid", inst_valid, 0);
    chk("s5b_no_req", imem.req_valid, 0);
    tick();
    chk("s5b_no_req2", imem.req_valid, 0);
    redir_valid = 1; redir_addr = 32'h400; tick(); redir_valid = 0;
    chk("s5b_req_addr", imem.req_addr, 32'h400);
    chk("s5b_trap_clear", trap, 0);

    // Asynchronous reset mid-WAIT, stale response after release.
    imem.req_ready = 1; tick();
    rst_n = 0; #1;
    check_reset("s6_async");
    tick();
    rst_n = 1; imem.rsp_valid = 1; imem.rsp_data = 32'hBADB_AD00; tick();
    chk("s6_inst_valid", inst_valid, 0);
    chk("s6_req_valid", imem.req_valid, 1);
    chk("s6_req_addr", imem.req_addr, RV);
    imem.rsp_valid = 1; imem.rsp_data = 32'hBADB_AD01; tick();
    chk("s6_late_rsp_ignored", inst_valid, 0);
    chk("s6_req_still_addr", imem.req_addr, RV);
    imem.req_ready = 1; tick();
    imem.rsp_valid = 1; imem.rsp_data = 32'h66; tick();
    chk("s6_inst", inst, 32'h66);
    chk("s6_inst_pc", inst_pc, RV);
    tick();

    // Redirect table with the automatic memory.
    mem_auto = 1; pend = 0; prev_hold = 0; in_trap = 0;
    for (int v = 0; v < 8; v++) begin
      if (!in_trap) wait_inst("tbl");
      redir_valid = 1; redir_addr = vecs[v].target; stall = vecs[v].stall;
      tick();
      redir_valid = 0; stall = 0;
      chk("tbl_trap", trap, vecs[v].exp_trap);
      chk("tbl_inst_valid", inst_valid, 0);
      if (vecs[v].exp_trap) begin
        chk("tbl_trap_addr", trap_addr, vecs[v].target);
        chk("tbl_no_req", imem.req_valid, 0);
      end else begin
        chk("tbl_req_valid", imem.req_valid, 1);
        chk("tbl_req_addr", imem.req_addr, vecs[v].exp_addr);
      end
      in_trap = vecs[v].exp_trap;
    end

    // pc wraps from the top word to zero.
    wait_inst("wrap");
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_inst", inst, mem_fn(32'hFFFF_FFFC));
    tick();
    chk("wrap_req_valid", imem.req_valid, 1);
    chk("wrap_req_addr", imem.req_addr, 32'h0);

    // Randomized run against the architectural PC stream.
    mem_auto = 0; rst_n = 0; tick();
    rst_n = 1; pend = 0; prev_hold = 0; mem_auto = 1;
    exp_pc = RV; consumed = 0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (acc_now) chk("rnd_req_addr", acc_addr, exp_pc);
      if (inst_valid) begin
        chk("rnd_inst_pc", inst_pc, exp_pc);
        chk("rnd_inst", inst, mem_fn(exp_pc));
      end
      stall = ($urandom_range(0, 3) == 0);
      redir_valid = 0;
      if (inst_valid && ($urandom_range(0, 7) == 0)) begin
        redir_valid = 1;
        redir_addr  = $urandom & 32'h0000_FFFC;
      end
      if (inst_valid) begin
        if (redir_valid) exp_pc = redir_addr;
        else if (!stall) begin
          exp_pc = exp_pc + 32'd4;
          consumed++;
        end
      end
    end
    redir_valid = 0; stall = 0;
    chk("rnd_progress", (consumed > 100) ? 32'd1 : 32'd0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
